// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor controller driving an external 4-bit adder.
// One nibble per cycle, LSB first; the final result, carry and overflow are registered.
module nibble_serial_add_ctrl #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*N_NIB-1:0]   op_a,
  input  logic [4*N_NIB-1:0]   op_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_c4,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * N_NIB;
  localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [KW+1:0]   nib_lo_s;
  logic            sub_unused_s;

  // Mode is fully captured in b_q/carry_q at acceptance; sub_q is kept for visibility only.
  assign sub_unused_s = sub_q;
  assign nib_lo_s     = {k_q, 2'b00};

  // Drive the external adder with the current nibble only while running.
  always_comb begin
    if (state_q == ST_RUN) begin
      add_a   = a_q[nib_lo_s +: 4];
      add_b   = b_q[nib_lo_s +: 4];
      add_cin = carry_q;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[nib_lo_s +: 4] = add_s;
        carry_d              = add_c4;
        if (k_q == K_LAST) begin
          k_d      = '0;
          state_d  = ST_DONE;
          result_d = acc_d;
          cout_d   = add_c4;
          // Signed overflow: like-signed operands producing a differently-signed sum.
          ovf_d    = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: N_NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- sub  in  1  0 = A+B+cin; 1 = A-B (two's complement).
- cin  in  1  carry-in for add mode; ignored when sub=1.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- add_a  out  4  nibble of A to the external 4-bit adder.
- add_b  out  4  nibble of B, or its complement, to the adder.
- add_cin  out  1  adder carry-in.
- add_s  in  4  adder sum, combinational from add_a/add_b/add_cin.
- add_c4  in  1  adder carry-out, the C[4] bit.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- result  out  W  final sum/difference.
- cout  out  1  carry-out of the MSB nibble.
- ovf  out  1  signed overflow flag.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE. Encoding is free.
REQ-005 In IDLE, start=1 at a rising edge SHALL perform all of the following:
- latch op_a into a_reg.
- latch op_b into b_reg, or ~op_b into b_reg when sub=1.
- latch sub into sub_reg.
- set carry_reg to cin, or to 1 when sub=1.
- clear nibble index k to 0 and clear result_reg.
- move to RUN.
REQ-006 While in IDLE, start=0 SHALL keep the block in IDLE.
REQ-007 In RUN, the adder outputs SHALL be combinational:
- add_a = a_reg[4k+3:4k].
- add_b = b_reg[4k+3:4k].
- add_cin = carry_reg.
REQ-008 At each RUN edge, the block SHALL perform all of the following:
- write result_reg[4k+3:4k] <= add_s.
- set carry_reg <= add_c4.
- increment k.
REQ-009 When k = N_NIB-1 at a RUN edge, the block SHALL move to DONE after the write.
REQ-010 The final RUN edge SHALL set cout <= add_c4.
REQ-011 The final RUN edge SHALL set ovf <= (a_reg[W-1] == b_reg[W-1]) AND (add_s[3] != a_reg[W-1]).
REQ-012 In add mode, cout SHALL be the raw carry-out.
REQ-013 In sub mode, cout=1 SHALL mean no borrow (A >= B unsigned).
REQ-014 RUN SHALL last exactly N_NIB cycles; the block SHALL never skip a nibble.
REQ-015 DONE SHALL last exactly one cycle; done=1 in DONE only, and the next state SHALL be IDLE.
REQ-016 Latency: with start sampled at edge 0, done SHALL be high during the cycle after edge N_NIB (edge 4 for N_NIB=4).
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 result, cout and ovf SHALL be driven from registers, update only on the final RUN edge, and hold until the next final RUN edge.
REQ-019 start asserted in RUN or DONE SHALL be ignored. It is not queued.
REQ-020 Changes on op_a, op_b, sub or cin after acceptance SHALL NOT affect the operation in progress.
REQ-021 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-022 Carry SHALL wrap out of the MSB nibble only into cout. Arithmetic SHALL be modulo 2^W.

Reset
REQ-023 rst_n=0 SHALL force the following immediately, regardless of clk:
- state = IDLE.
- k = 0.
- carry_reg = 0.
- a_reg = 0, b_reg = 0, sub_reg = 0.
- result = 0, cout = 0, ovf = 0.
- busy = 0, done = 0.
- add_a = 0, add_b = 0, add_cin = 0.
REQ-024 Reset asserted during RUN SHALL abandon the operation with no done pulse.
REQ-025 After rst_n rises, the first start SHALL be accepted normally.

Verification
REQ-026 The bench SHALL cover the following scenarios, with N_NIB=4 and a behavioural 4-bit adder model:
- Add 0x0001 + 0xFFFF, cin=0 -> result 0x0000, cout=1, ovf=0, done high in the cycle after edge 4.
- Add 0x7FFF + 0x0001, cin=0 -> result 0x8000, cout=0, ovf=1. Per-cycle add_cin trace SHALL be 0,1,1,1.
- Sub 0x0005 - 0x0007 -> result 0xFFFE, cout=0, ovf=0. First RUN cycle SHALL show add_b=0x8 and add_cin=1.
- Add 0x1234 + 0x1111, cin=1 -> result 0x2346, cout=0. A second start pulsed during RUN SHALL produce no extra done, and result SHALL be unchanged.
- rst_n pulled low after the 2nd RUN edge -> busy and outputs SHALL go to 0 at once with no done. A subsequent 0x00FF + 0x0001 SHALL give 0x0100.
- Back-to-back: start held high continuously -> one operation SHALL complete every N_NIB+2 cycles, with done pulses separated by 6 cycles.
